adc_burst_packer: RTL
=====================

# adc_burst_packer

Downstream neighbour of the ADC capture stage. The capture stage emits a free-running 32-bit AXI-Stream with no backpressure. This block absorbs that stream into a FIFO, splits it into bounded bursts with `m_axis_tlast` for the DMA writer, and honours `tready`. It drops and counts words on overflow and never stalls its source. It sits between the ADC core and the DDR burst writer.

## Interface
- `DEPTH`, 64: FIFO depth in words. Power of two, 8..1024.
- `BURST_LEN`, 32: maximum beats per output burst. Must be ≤ DEPTH.
- `IDLE_TIMEOUT`, 256: idle input cycles before a partial burst is flushed. Must be ≥ 1.
- `aclk` in 1: system clock. Single clock domain.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tvalid` in 1: input word valid. There is no tready; every valid word is taken or dropped.
- `s_axis_tlast` in 1: input end of series.
- `s_axis_tdata` in 32: sample word, passed through unmodified.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tready` in 1: downstream accept.
- `m_axis_tdata` out 32: output word.
- `m_axis_tlast` out 1: last beat of the burst.
- `clear_stats` in 1: synchronous clear of the statistics counters and the sticky flag.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `dropped_count` out 32: words lost to a full FIFO. Saturates at 0xFFFFFFFF.
- `bursts_sent` out 32: completed output bursts. Wraps.
- `overflow` out 1: sticky; set on the first dropped word.

## Operation
- FIFO entries are 33 bits: {tlast, tdata}. The read side is first-word-fall-through.
- Write rule:
  - If `s_axis_tvalid` is high and the registered `full` is low, the word is written.
  - If `full` is high, the word is dropped, `dropped_count` increments and `overflow` is set.
  - There is no write-through when full, even if a read happens in the same cycle.
- `pending_last` counts stored entries that carry tlast. It increments on a write with tlast and decrements on a read of such an entry. Simultaneous increment and decrement leave it unchanged.
- `idle_cnt` resets to 0 on every input valid. Otherwise it increments and saturates at IDLE_TIMEOUT.
- State machine: IDLE and BURST.
  - IDLE → BURST when the level is ≥ BURST_LEN, or `pending_last` > 0, or (the level is > 0 and `idle_cnt` == IDLE_TIMEOUT).
  - On entering BURST, `beat` is set to 0.
  - In BURST, `m_axis_tvalid` = FIFO not empty.
  - `m_axis_tlast` = (beat == BURST_LEN-1) OR stored tlast OR (the level is 1 and the burst was started by timeout).
  - On each handshake, `beat` increments and the head is popped.
  - A handshake with `m_axis_tlast` = 1 returns the FSM to IDLE and increments `bursts_sent`.
  - While in BURST and the FIFO runs empty, `m_axis_tvalid` goes low and the FSM stays in BURST until the next word arrives.
- AXI rules:
  - Once `m_axis_tvalid` is asserted, tdata and tlast hold stable until the handshake.
  - `m_axis_tvalid` never drops without a handshake. This holds because the FIFO is only popped on a handshake.
- `clear_stats` zeroes `dropped_count`, `bursts_sent` and `overflow`. It does not touch the FIFO or the FSM. If `clear_stats` coincides with a drop, the clear wins and the counter reads 0.

## Timing
- Reset values:
  - All outputs 0.
  - FIFO empty.
  - State IDLE.
  - `pending_last`, `idle_cnt` and `beat` are 0.
- Write at edge N: `fifo_level` reflects it after edge N. The word is visible at the FIFO head in cycle N+1.
- The IDLE → BURST decision uses registered level and flags. `m_axis_tvalid` rises one cycle after the triggering condition is visible. Minimum input-to-output latency is 2 cycles.
- Throughput: one beat per cycle while `tready` = 1 and the FIFO is non-empty. There is no bubble between the end of one burst and the next burst's decision cycle. Exactly one IDLE cycle separates bursts.
- Full and empty flags are registered and update on the same edge as the pointers. A simultaneous read and write at a full FIFO pops one word and drops one word.
- Pointers are $clog2(DEPTH)+1 bits so that full can be distinguished from empty. Wrap-around is natural modulo 2·DEPTH.
- Asserting `aresetn` mid-burst discards all stored data and drops `m_axis_tvalid` immediately, asynchronously.

## Structure
- Shared package `adc_pkg`:
  - Constant `ADC_WORD_W` = 32.
  - FIFO entry typedef {last, data}.
  - State enum {ST_IDLE, ST_BURST}.
- Sub-module `sync_fifo_fwft` with parameters DEPTH and WIDTH=33. It exposes `wr_en`, `rd_en`, `full`, `empty` and `level`. Write-while-full is ignored inside the FIFO.
- The top level holds the FSM, `pending_last`, `idle_cnt`, `beat` and the statistics.

## Test plan
All scenarios use DEPTH=64, BURST_LEN=32, IDLE_TIMEOUT=16.
- 100 contiguous words with `tready` = 1, tlast on word 100:
  - Bursts of 32, 32, 32 and 4 beats, with tlast on beats 32, 64, 96 and 100.
  - `bursts_sent` = 4, `dropped_count` = 0.
- 5 words without tlast, then 20 idle cycles:
  - One burst of 5 beats, tlast on beat 5.
  - It starts 17 cycles after the last input word.
- `tready` = 0 while 70 contiguous words are written:
  - `fifo_level` = 64, `dropped_count` = 6, `overflow` = 1.
  - Releasing `tready` yields 2 bursts of 32 carrying words 1..64 in order.
- Random `tready` (50%) with continuous input of 1000 words and tlast every 50:
  - Output order is preserved.
  - Every input tlast appears as an output tlast.
  - No burst exceeds 32 beats.
  - tdata and tlast stay stable while tvalid=1 and tready=0.
- `aresetn` pulsed low mid-burst after 10 beats:
  - All outputs 0 and FIFO empty.
  - 40 new words afterwards yield a burst of 32 starting with the first new word.
- `clear_stats` in the same cycle as a drop:
  - `dropped_count` = 0 and `overflow` = 0 the next cycle.
  - The next drop gives `dropped_count` = 1.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types for the ADC burst packer: word width, FIFO entry layout and FSM states.
package adc_pkg;

   localparam int ADC_WORD_W = 32;

   typedef struct packed {
      logic                  last;
      logic [ADC_WORD_W-1:0] data;
   } fifo_entry_t;

   typedef enum logic {
      ST_IDLE,
      ST_BURST
   } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/level flags.
module sync_fifo_fwft #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 33
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             wr_do, rd_do;

   // Pointers carry one extra bit so full and empty differ; level is their modular difference.
   always_comb begin
      wr_do    = wr_en & ~full_q;
      rd_do    = rd_en & ~empty_q;
      wr_ptr_d = wr_ptr_q + (AW+1)'(wr_do);
      rd_ptr_d = rd_ptr_q + (AW+1)'(rd_do);
      level_d  = wr_ptr_d - rd_ptr_d;
      full_d   = (level_d == (AW+1)'(DEPTH));
      empty_d  = (level_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_do) begin
         mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   assign rd_data = mem[rd_ptr_q[AW-1:0]];
   assign full    = full_q;
   assign empty   = empty_q;
   assign level   = level_q;

endmodule

// File: rtl/adc_burst_packer.sv
// Absorbs a free-running ADC stream into a FIFO and re-emits it as bounded AXI-Stream bursts
// with tlast, dropping and counting words when the FIFO is full.
module adc_burst_packer
   import adc_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int BURST_LEN    = 32,
   parameter int IDLE_TIMEOUT = 256
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   input  logic [ADC_WORD_W-1:0]   s_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [ADC_WORD_W-1:0]   m_axis_tdata,
   output logic                    m_axis_tlast,
   input  logic                    clear_stats,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [31:0]             dropped_count,
   output logic [31:0]             bursts_sent,
   output logic                    overflow
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   localparam int BW = $clog2(BURST_LEN + 1);

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   fifo_entry_t   wr_entry, head;
   logic          fifo_full, fifo_empty;
   logic [LW-1:0] level;

   state_t        state_q, state_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          by_timeout_q, by_timeout_d;
   logic          last_hold_q, last_hold_d;
   logic [LW-1:0] pending_q, pending_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [31:0]   dropped_q, dropped_d;
   logic [31:0]   bursts_q, bursts_d;
   logic          overflow_q, overflow_d;

   logic          tvalid, tlast, hs, drop, wr_last;
   logic          start_len, start_last, start_to;

   assign wr_entry = '{last: s_axis_tlast, data: s_axis_tdata};

   sync_fifo_fwft #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fifo_entry_t))
   ) u_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .wr_en   (s_axis_tvalid),
      .wr_data (wr_entry),
      .rd_en   (hs),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      by_timeout_d = by_timeout_q;
      last_hold_d  = last_hold_q;
      pending_d    = pending_q;
      idle_d       = idle_q;
      dropped_d    = dropped_q;
      bursts_d     = bursts_q;
      overflow_d   = overflow_q;
      tvalid       = 1'b0;
      tlast        = 1'b0;
      hs           = 1'b0;

      drop       = s_axis_tvalid & fifo_full;
      wr_last    = s_axis_tvalid & ~fifo_full & s_axis_tlast;
      start_len  = (level >= LW'(BURST_LEN));
      start_last = (pending_q != '0);
      start_to   = (level != '0) && (idle_q == IW'(IDLE_TIMEOUT));

      case (state_q)
         ST_IDLE: begin
            if (start_len || start_last || start_to) begin
               state_d      = ST_BURST;
               beat_d       = '0;
               by_timeout_d = start_to & ~start_len & ~start_last;
            end
         end
         ST_BURST: begin
            tvalid = ~fifo_empty;
            // last_hold keeps tlast stable if the level term changes while the beat is stalled
            tlast  = tvalid & ((beat_q == BW'(BURST_LEN - 1)) | head.last |
                               ((level == LW'(1)) & by_timeout_q) | last_hold_q);
            hs     = tvalid & m_axis_tready;
            if (hs) begin
               beat_d      = beat_q + BW'(1);
               last_hold_d = 1'b0;
               if (tlast) begin
                  state_d  = ST_IDLE;
                  bursts_d = bursts_q + 32'd1;
               end
            end else if (tlast) begin
               last_hold_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case ({wr_last, hs & head.last})
         2'b10:   pending_d = pending_q + LW'(1);
         2'b01:   pending_d = pending_q - LW'(1);
         default: pending_d = pending_q;
      endcase

      if (s_axis_tvalid) begin
         idle_d = '0;
      end else if (idle_q != IW'(IDLE_TIMEOUT)) begin
         idle_d = idle_q + IW'(1);
      end

      if (drop) begin
         dropped_d  = sat_inc32(dropped_q);
         overflow_d = 1'b1;
      end
      if (clear_stats) begin
         dropped_d  = '0;
         bursts_d   = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= ST_IDLE;
         beat_q       <= '0;
         by_timeout_q <= 1'b0;
         last_hold_q  <= 1'b0;
         pending_q    <= '0;
         idle_q       <= '0;
         dropped_q    <= '0;
         bursts_q     <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         by_timeout_q <= by_timeout_d;
         last_hold_q  <= last_hold_d;
         pending_q    <= pending_d;
         idle_q       <= idle_d;
         dropped_q    <= dropped_d;
         bursts_q     <= bursts_d;
         overflow_q   <= overflow_d;
      end
   end

   assign m_axis_tvalid = tvalid;
   assign m_axis_tdata  = tvalid ? head.data : '0;
   assign m_axis_tlast  = tlast;
   assign fifo_level    = level;
   assign dropped_count = dropped_q;
   assign bursts_sent   = bursts_q;
   assign overflow      = overflow_q;

endmodule
